// File: rtl/regfile_write_arbiter_if.sv
// Write-request bundle for regfile_write_arbiter: two valid/ready
// requesters (A = ALU writeback, B = memory load) sharing one write port.
interface regfile_write_arbiter_if #(
    parameter int N = 8,
    parameter int A = 2
);
    logic         a_valid;
    logic [A-1:0] a_addr;
    logic [N-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [A-1:0] b_addr;
    logic [N-1:0] b_data;
    logic         b_ready;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register bank of 2**A x N bits with a single write port shared by two
// requesters under round-robin arbitration, a one-register-per-cycle
// clear sweep and an asynchronous read port.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | normal arbitration between A and B
//   SWEEP | bank being zeroed, reg[idx] cleared each cycle
module regfile_write_arbiter #(
    parameter int N = 8,
    parameter int A = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    regfile_write_arbiter_if.slave   wr,
    input  logic                     clear,
    output logic                     busy,
    output logic                     last_grant,
    input  logic [A-1:0]             rd_addr,
    output logic [N-1:0]             rd_data
);
    localparam int R = 1 << A;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t       state;
    logic [A-1:0] idx;
    logic [N-1:0] bank [R];
    logic         a_fire;
    logic         b_fire;

    // Grant: clear and an active sweep block both requesters; on a tie the
    // requester that did not win last time goes first.
    always_comb begin
        wr.a_ready = 1'b0;
        wr.b_ready = 1'b0;
        if (state == IDLE && !clear) begin
            if (wr.a_valid && wr.b_valid) begin
                if (last_grant) begin
                    wr.a_ready = 1'b1;
                end else begin
                    wr.b_ready = 1'b1;
                end
            end else begin
                wr.a_ready = wr.a_valid;
                wr.b_ready = wr.b_valid;
            end
        end
    end

    assign a_fire = wr.a_valid && wr.a_ready;
    assign b_fire = wr.b_valid && wr.b_ready;

    // Asynchronous read; a same-cycle write only lands on the next edge.
    assign rd_data = bank[rd_addr];

    // Controller state, sweep index, grant history and the bank itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            last_grant <= 1'b1;
            for (int i = 0; i < R; i++) begin
                bank[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= SWEEP;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end else if (a_fire) begin
                        bank[wr.a_addr] <= wr.a_data;
                        last_grant      <= 1'b0;
                    end else if (b_fire) begin
                        bank[wr.b_addr] <= wr.b_data;
                        last_grant      <= 1'b1;
                    end
                end
                SWEEP: begin
                    bank[idx] <= '0;
                    idx       <= idx + A'(1);
                    if (idx == A'(R - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, contention,
// same-address collision, clear sweep and reset during a sweep.
module tb_regfile_write_arbiter;
    logic       clock;
    logic       reset;
    logic       clear;
    logic       busy;
    logic       last_grant;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    int         checks;
    int         errors;

    regfile_write_arbiter_if #(.N(8), .A(2)) wr ();

    regfile_write_arbiter #(.N(8), .A(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr         (wr),
        .clear      (clear),
        .busy       (busy),
        .last_grant (last_grant),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic read_reg(input int a, output logic [7:0] v);
        rd_addr = 2'(a);
        #1;
        v = rd_data;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic idle_inputs;
        wr.a_valid = 1'b0;
        wr.a_addr  = 2'd0;
        wr.a_data  = 8'h00;
        wr.b_valid = 1'b0;
        wr.b_addr  = 2'd0;
        wr.b_data  = 8'h00;
        clear      = 1'b0;
        rd_addr    = 2'd0;
    endtask

    task automatic preload;
        for (int i = 0; i < 4; i++) begin
            wr.a_valid = 1'b1;
            wr.a_addr  = 2'(i);
            wr.a_data  = 8'(i + 1);
            tick();
        end
        wr.a_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        idle_inputs();
        wr.a_valid = 1'b1;
        wr.a_data  = 8'h77;
        wr.b_valid = 1'b1;
        wr.b_addr  = 2'd1;
        wr.b_data  = 8'h88;
        apply_reset();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (last_grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_last_grant: got %b expected 1", last_grant);
        end
        checks++;
        if (wr.a_ready !== 1'b1 || wr.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: got a_ready=%b b_ready=%b expected 1/0",
                     wr.a_ready, wr.b_ready);
        end
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected 00", i, v);
            end
        end
        wr.a_valid = 1'b0;
        wr.b_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_write;
        idle_inputs();
        apply_reset();
        wr.a_valid = 1'b1;
        wr.a_addr  = 2'd2;
        wr.a_data  = 8'h0A;
        rd_addr    = 2'd2;
        #1;
        checks++;
        if (wr.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b expected 1", wr.a_ready);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL single_old_value: got %h expected 00", rd_data);
        end
        tick();
        wr.a_valid = 1'b0;
        #1;
        checks++;
        if (rd_data !== 8'h0A) begin
            errors++;
            $display("FAIL single_new_value: got %h expected 0a", rd_data);
        end
        checks++;
        if (last_grant !== 1'b0) begin
            errors++;
            $display("FAIL single_last_grant: got %b expected 0", last_grant);
        end
    endtask

    task automatic test_contention;
        logic       exp_a;
        logic [7:0] v;
        idle_inputs();
        apply_reset();
        wr.a_valid = 1'b1;
        wr.a_addr  = 2'd1;
        wr.a_data  = 8'h11;
        wr.b_valid = 1'b1;
        wr.b_addr  = 2'd3;
        wr.b_data  = 8'h33;
        for (int c = 0; c < 4; c++) begin
            exp_a = (c % 2 == 0);
            #1;
            checks++;
            if (wr.a_ready !== exp_a || wr.b_ready !== !exp_a) begin
                errors++;
                $display("FAIL contention_grant%0d: got a_ready=%b b_ready=%b expected %b/%b",
                         c, wr.a_ready, wr.b_ready, exp_a, !exp_a);
            end
            tick();
            checks++;
            if (last_grant !== !exp_a) begin
                errors++;
                $display("FAIL contention_last_grant%0d: got %b expected %b",
                         c, last_grant, !exp_a);
            end
            if (exp_a) begin
                wr.a_data = wr.a_data + 8'h01;
            end else begin
                wr.b_data = wr.b_data + 8'h01;
            end
        end
        wr.a_valid = 1'b0;
        wr.b_valid = 1'b0;
        read_reg(1, v);
        checks++;
        if (v !== 8'h12) begin
            errors++;
            $display("FAIL contention_reg1: got %h expected 12", v);
        end
        read_reg(3, v);
        checks++;
        if (v !== 8'h34) begin
            errors++;
            $display("FAIL contention_reg3: got %h expected 34", v);
        end
    endtask

    task automatic test_collision;
        idle_inputs();
        apply_reset();
        wr.a_valid = 1'b1;
        wr.a_data  = 8'hAA;
        wr.b_valid = 1'b1;
        wr.b_data  = 8'hBB;
        #1;
        checks++;
        if (wr.a_ready !== 1'b1 || wr.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision_first: got a_ready=%b b_ready=%b expected 1/0",
                     wr.a_ready, wr.b_ready);
        end
        tick();
        wr.a_valid = 1'b0;
        #1;
        checks++;
        if (rd_data !== 8'hAA) begin
            errors++;
            $display("FAIL collision_after_a: got %h expected aa", rd_data);
        end
        checks++;
        if (wr.b_ready !== 1'b1) begin
            errors++;
            $display("FAIL collision_second: got b_ready=%b expected 1", wr.b_ready);
        end
        tick();
        wr.b_valid = 1'b0;
        #1;
        checks++;
        if (rd_data !== 8'hBB) begin
            errors++;
            $display("FAIL collision_final: got %h expected bb", rd_data);
        end
    endtask

    task automatic test_clear_sweep;
        logic [7:0] v;
        int         busy_cycles;
        int         blocked_cycles;
        idle_inputs();
        apply_reset();
        preload();
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            checks++;
            if (v !== 8'(i + 1)) begin
                errors++;
                $display("FAIL clear_preload%0d: got %h expected %h", i, v, 8'(i + 1));
            end
        end
        wr.a_valid = 1'b1;
        wr.a_addr  = 2'd2;
        wr.a_data  = 8'h5A;
        clear      = 1'b1;
        busy_cycles    = 0;
        blocked_cycles = 0;
        #1;
        if (wr.a_ready === 1'b0) blocked_cycles++;
        if (busy === 1'b1) busy_cycles++;
        tick();
        clear = 1'b0;
        for (int c = 0; c < 6 && wr.a_ready !== 1'b1; c++) begin
            if (wr.a_ready === 1'b0) blocked_cycles++;
            if (busy === 1'b1) busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles != 4) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d cycles expected 4", busy_cycles);
        end
        checks++;
        if (blocked_cycles != 5) begin
            errors++;
            $display("FAIL clear_ready_blocked: got %0d cycles expected 5", blocked_cycles);
        end
        checks++;
        if (busy !== 1'b0 || wr.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_first_idle: got busy=%b a_ready=%b expected 0/1",
                     busy, wr.a_ready);
        end
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL clear_reg%0d: got %h expected 00", i, v);
            end
        end
        tick();
        wr.a_valid = 1'b0;
        read_reg(2, v);
        checks++;
        if (v !== 8'h5A) begin
            errors++;
            $display("FAIL clear_pending_write: got %h expected 5a", v);
        end
    endtask

    task automatic test_reset_mid_sweep;
        logic [7:0] v;
        idle_inputs();
        apply_reset();
        preload();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_busy: got %b expected 0", busy);
        end
        checks++;
        if (last_grant !== 1'b1) begin
            errors++;
            $display("FAIL midsweep_last_grant: got %b expected 1", last_grant);
        end
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL midsweep_reg%0d: got %h expected 00", i, v);
            end
        end
        wr.b_valid = 1'b1;
        #1;
        checks++;
        if (wr.b_ready !== 1'b1) begin
            errors++;
            $display("FAIL midsweep_idle_grant: got b_ready=%b expected 1", wr.b_ready);
        end
        wr.b_valid = 1'b0;
        tick();
    endtask

    // Ready outputs must never both be high outside reset.
    always @(negedge clock) begin
        if (reset === 1'b0 && wr.a_ready === 1'b1 && wr.b_ready === 1'b1) begin
            errors++;
            $display("FAIL ready_exclusive: got a_ready=1 b_ready=1 expected at most one");
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_collision();
        test_clear_sweep();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
